// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
//   Shared definitions for the configuration-chain bitstream loader:
//   - ccff_state_e : loader FSM states (2-bit encoding)
//   - ccff_cnt_w() : width of a counter that must hold values 0 .. n-1,
//                    never narrower than one bit
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } ccff_state_e;

  // Counter width for a terminal count of n-1; a count of 1 or 2 still
  // needs a real 1-bit register, so clamp to 1.
  function automatic int unsigned ccff_cnt_w(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : ccff_loader_pkg

// File: rtl/ccff_release_timer.sv
// ---------------------------------------------------------------------------
// ccff_release_timer
//   Counts the cycles spent waiting between cfg_done and fabric reset release.
//   Ports:
//     clk      in  programming clock, rising edge
//     rst_n    in  asynchronous active-low reset
//     start    in  restart the count from zero on this edge
//     en       in  count this cycle (loader is in RELEASE)
//     expired  out high during the DLY-th enabled cycle after start
// ---------------------------------------------------------------------------
module ccff_release_timer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned DLY = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  output logic expired
);

  localparam int unsigned         CNT_W    = ccff_cnt_w(DLY);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DLY - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The count is zero on the first enabled cycle, so reaching CNT_LAST
  // marks the DLY-th cycle; the owner leaves RELEASE on that edge.
  assign expired = en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : ccff_release_timer

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//   Shifts a streamed bitstream into the fabric configuration chains, one
//   column (one bit per chain) per valid/ready handshake. After CHAIN_LEN
//   columns it raises cfg_done and, RELEASE_DLY cycles later, releases the
//   fabric reset.
//   Ports:
//     prog_clock     in   programming clock, rising edge
//     global_resetn  in   asynchronous active-low reset
//     start          in   begin a load (honoured in IDLE/DONE only)
//     abort          in   synchronous abort back to IDLE, highest priority
//     bs_data        in   column; bit i feeds chain i
//     bs_valid       in   bs_data valid
//     bs_ready       out  column accepted this cycle when bs_valid is high
//     ccff_head      out  registered chain inputs
//     ccff_shift_en  out  chains shift on the next edge when high
//     ccff_tail      in   chain outputs (old contents shifting out)
//     tail_xor       out  running XOR of tail bits shifted out this load
//     cfg_busy       out  loading columns
//     cfg_done       out  all columns loaded (RELEASE or DONE)
//     fabric_resetn  out  fabric reset, high only in DONE
// ---------------------------------------------------------------------------
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned NUM_CHAINS  = 10,
  parameter int unsigned CHAIN_LEN   = 4096,
  parameter int unsigned RELEASE_DLY = 16
) (
  input  logic                  prog_clock,
  input  logic                  global_resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_CHAINS-1:0] bs_data,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift_en,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic [NUM_CHAINS-1:0] tail_xor,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  fabric_resetn
);

  localparam int unsigned      COL_W    = ccff_cnt_w(CHAIN_LEN);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHAIN_LEN - 1);

  ccff_state_e           state_q,     state_d;
  logic [COL_W-1:0]      col_q,       col_d;
  logic [NUM_CHAINS-1:0] head_q,      head_d;
  logic                  shift_en_q,  shift_en_d;
  logic [NUM_CHAINS-1:0] tail_xor_q,  tail_xor_d;
  logic                  fab_rstn_q,  fab_rstn_d;

  logic accept;
  logic start_ok;
  logic last_accept;
  logic dly_expired;

  assign bs_ready    = (state_q == ST_LOAD);
  assign accept      = bs_valid && bs_ready;
  assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Computed without the timer output so the timer restart never depends
  // on its own expiry through the next-state logic.
  assign last_accept = accept && (col_q == LAST_COL) && !abort;

  ccff_release_timer #(
    .DLY (RELEASE_DLY)
  ) u_release_timer (
    .clk     (prog_clock),
    .rst_n   (global_resetn),
    .start   (last_accept),
    .en      (state_q == ST_RELEASE),
    .expired (dly_expired)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    tail_xor_d = tail_xor_q;

    if (abort) begin
      // Pending column is dropped; head and tail_xor keep their values.
      state_d = ST_IDLE;
    end else if (start_ok) begin
      state_d    = ST_LOAD;
      col_d      = '0;
      tail_xor_d = '0;
    end else begin
      // The shift requested last cycle happens on this edge, including the
      // final column's shift during the first RELEASE cycle.
      if (shift_en_q) begin
        tail_xor_d = tail_xor_q ^ ccff_tail;
      end
      unique case (state_q)
        ST_LOAD: begin
          if (accept) begin
            head_d     = bs_data;
            shift_en_d = 1'b1;
            if (col_q == LAST_COL) begin
              state_d = ST_RELEASE;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (dly_expired) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end

    fab_rstn_d = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clock or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      head_q     <= '0;
      shift_en_q <= 1'b0;
      tail_xor_q <= '0;
      fab_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      tail_xor_q <= tail_xor_d;
      fab_rstn_q <= fab_rstn_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign tail_xor      = tail_xor_q;
  assign cfg_busy      = (state_q == ST_LOAD);
  assign cfg_done      = (state_q == ST_RELEASE) || (state_q == ST_DONE);
  assign fabric_resetn = fab_rstn_q;

endmodule : ccff_bitstream_loader

// File: tb/tb_ccff_bitstream_loader.sv
module tb_ccff_bitstream_loader;

  localparam int unsigned NC = 2;
  localparam int unsigned CL = 4;
  localparam int unsigned RD = 3;

  logic          prog_clock = 1'b0;
  logic          global_resetn;
  logic          start;
  logic          abort;
  logic [NC-1:0] bs_data;
  logic          bs_valid;
  logic          bs_ready;
  logic [NC-1:0] ccff_head;
  logic          ccff_shift_en;
  logic [NC-1:0] ccff_tail;
  logic [NC-1:0] tail_xor;
  logic          cfg_busy;
  logic          cfg_done;
  logic          fabric_resetn;

  always #5 prog_clock = ~prog_clock;

  ccff_bitstream_loader #(
    .NUM_CHAINS  (NC),
    .CHAIN_LEN   (CL),
    .RELEASE_DLY (RD)
  ) dut (
    .prog_clock    (prog_clock),
    .global_resetn (global_resetn),
    .start         (start),
    .abort         (abort),
    .bs_data       (bs_data),
    .bs_valid      (bs_valid),
    .bs_ready      (bs_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .tail_xor      (tail_xor),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .fabric_resetn (fabric_resetn)
  );

  // Configuration chains: 4-bit shift registers, new bit enters at bit 0,
  // tail is bit 3.
  logic [3:0] chain    [NC];
  logic [3:0] seed_val [NC];
  logic       seed_load = 1'b0;

  always @(posedge prog_clock) begin
    for (int i = 0; i < NC; i++) begin
      if (seed_load)          chain[i] <= seed_val[i];
      else if (ccff_shift_en) chain[i] <= {chain[i][2:0], ccff_head[i]};
    end
  end

  assign ccff_tail = {chain[1][3], chain[0][3]};

  // Reference model: phase 0=idle 1=loading 2=waiting release 3=done.
  int         phase    = 0;
  int         cnt      = 0;
  int         rel_left = 0;
  bit         m_shift  = 1'b0;
  logic [NC-1:0] m_head = '0;
  logic [3:0] m_chain [NC];
  logic [3:0] m_prev  [NC];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] exp_txor();
    logic [NC-1:0] e;
    for (int i = 0; i < NC; i++) e[i] = ^m_prev[i];
    return e;
  endfunction

  // One clock cycle: drive inputs, advance the model, check outputs.
  task automatic step(input bit st, input bit ab, input bit v, input logic [NC-1:0] d);
    start = st; abort = ab; bs_valid = v; bs_data = d;
    chk("bs_ready", bs_ready, (phase == 1));
    @(posedge prog_clock);
    if (ab) begin
      phase = 0; m_shift = 1'b0;
    end else if (st && (phase == 0 || phase == 3)) begin
      phase = 1; cnt = 0; m_shift = 1'b0;
      m_prev = m_chain;
    end else begin
      case (phase)
        1: begin
          m_shift = v;
          if (v) begin
            m_head = d;
            for (int i = 0; i < NC; i++) m_chain[i] = {m_chain[i][2:0], d[i]};
            cnt++;
            if (cnt == CL) begin phase = 2; rel_left = RD; end
          end
        end
        2: begin
          m_shift = 1'b0;
          rel_left--;
          if (rel_left == 0) phase = 3;
        end
        default: m_shift = 1'b0;
      endcase
    end
    #1;
    seed_load = 1'b0;
    chk("shift_en", ccff_shift_en, m_shift);
    chk("cfg_busy", cfg_busy, (phase == 1));
    chk("cfg_done", cfg_done, (phase == 2 || phase == 3));
    chk("fabric_resetn", fabric_resetn, (phase == 3));
    if (m_shift) chk("ccff_head", ccff_head, m_head);
    if (phase == 3) chk("tail_xor", tail_xor, exp_txor());
  endtask

  // Chains take the seed on the next edge; call only while no shift is pending.
  task automatic seed(input logic [3:0] s0, input logic [3:0] s1);
    seed_val[0] = s0; seed_val[1] = s1;
    m_chain[0]  = s0; m_chain[1]  = s1;
    seed_load   = 1'b1;
    step(0, 0, 0, '0);
  endtask

  task automatic check_chains(input string tag);
    for (int i = 0; i < NC; i++) chk(tag, chain[i], m_chain[i]);
  endtask

  // Runs until the model reaches DONE, bounded by a cycle budget.
  task automatic finish_load(input bit gaps, input bit rand_start);
    int n = 0;
    while (phase != 3 && n < 60) begin
      step(rand_start && ($urandom_range(0, 7) == 0), 0,
           gaps ? ($urandom_range(0, 1) == 1) : 1'b1, 2'($urandom_range(0, 3)));
      n++;
    end
    chk("load_completes", fabric_resetn, 1);
    check_chains("chain_contents");
  endtask

  logic [NC-1:0] cols [4];

  initial begin
    cols[0] = 2'b01; cols[1] = 2'b10; cols[2] = 2'b11; cols[3] = 2'b00;
    m_chain[0] = '0; m_chain[1] = '0;
    m_prev[0]  = '0; m_prev[1]  = '0;
    global_resetn = 1'b0;
    start = 0; abort = 0; bs_valid = 0; bs_data = '0;

    // Reset state
    repeat (2) @(posedge prog_clock);
    #1;
    chk("rst_bs_ready", bs_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_tail_xor", tail_xor, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_fabric_resetn", fabric_resetn, 0);
    global_resetn = 1'b1;

    // Idle without start
    for (int k = 0; k < 20; k++) step(0, 0, 0, '0);

    // Back-to-back load of the directed columns
    seed(4'b1010, 4'b0110);
    step(1, 0, 0, '0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, cols[k]);
    chk("dir_cfg_done_with_last_shift", cfg_done, 1);
    for (int k = 0; k < int'(RD); k++) step(0, 0, 0, '0);
    chk("dir_fabric_resetn", fabric_resetn, 1);
    chk("dir_chain0", chain[0], 4'b1010);
    chk("dir_chain1", chain[1], 4'b0110);
    chk("dir_tail_xor", tail_xor, 2'b00);

    // Same load with bs_valid low every other cycle; start issued from DONE
    seed(4'b1010, 4'b0110);
    step(1, 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, cols[k]);
      step(0, 0, 0, 2'b11);
    end
    for (int k = 0; k < int'(RD); k++) step(0, 0, 0, '0);
    chk("gap_chain0", chain[0], 4'b1010);
    chk("gap_chain1", chain[1], 4'b0110);
    chk("gap_tail_xor", tail_xor, 2'b00);

    // Abort after two accepts with a third column on offer
    seed(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    step(1, 0, 0, '0);
    step(0, 0, 1, 2'($urandom_range(0, 3)));
    step(0, 0, 1, 2'($urandom_range(0, 3)));
    step(0, 1, 1, 2'($urandom_range(0, 3)));
    for (int k = 0; k < 3; k++) step(0, 0, 1, 2'($urandom_range(0, 3)));
    chk("abort_cfg_done", cfg_done, 0);
    step(1, 0, 0, '0);
    finish_load(0, 0);

    // Surplus columns offered after the last one, then start from DONE
    seed(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    step(1, 0, 0, '0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 2'($urandom_range(0, 3)));
    for (int k = 0; k < 5; k++) step(0, 0, 1, 2'b11);
    check_chains("surplus_not_consumed");
    step(1, 0, 0, '0);
    chk("restart_fabric_resetn_low", fabric_resetn, 0);
    finish_load(1, 1);

    // Randomized loads with gaps and stray start pulses
    for (int r = 0; r < 6; r++) begin
      seed(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step(1, 0, 0, '0);
      finish_load(1, 1);
    end

    // Asynchronous reset mid-load
    seed(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    step(1, 0, 0, '0);
    step(0, 0, 1, 2'b11);
    step(0, 0, 1, 2'b11);
    #3;
    global_resetn = 1'b0;
    #1;
    chk("arst_bs_ready", bs_ready, 0);
    chk("arst_head", ccff_head, 0);
    chk("arst_shift_en", ccff_shift_en, 0);
    chk("arst_tail_xor", tail_xor, 0);
    chk("arst_cfg_busy", cfg_busy, 0);
    chk("arst_cfg_done", cfg_done, 0);
    phase = 0; m_shift = 1'b0; m_head = '0;
    @(posedge prog_clock);
    #1;
    global_resetn = 1'b1;
    seed(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    step(1, 0, 0, '0);
    finish_load(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
